nrisc_pipe_fwd: RTL and testbench
=================================

Name: nrisc_pipe_fwd

Overview:
Parametrised execute/writeback pipeline tracker for the next-generation NRISC core. It holds destination, control and result for every in-flight instruction and forwards the youngest matching result onto two ALU operands. It detects load-use hazards, handles external stall and flush, drives the register-file writeback port and counts retired instructions. It sits between the instruction decoder/ALU and NRISC_REGs/D-Data, replacing the fixed two-stage pipe registers and single-stage forwarding muxes.

Parameters:
TAM, 16, data/operand width
REG_AW, 4, register address width
FWD_DEPTH, 2, in-flight stages tracked (stage 0 = exec, stage FWD_DEPTH-1 = writeback); legal range 2..4
CNT_W, 16, width of retire_cnt
SEL_W, $clog2(FWD_DEPTH+1), width of forward-select outputs

Ports:
clk  in  1  main clock, rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  decoder presents an instruction to issue
id_write  in  1  instruction writes id_rd
id_load  in  1  result comes from D-Data, not the ALU
id_rd  in  REG_AW  destination register
id_rs_a, id_rs_b  in  REG_AW  source registers
id_use_a, id_use_b  in  1  source actually read
reg_a, reg_b  in  TAM  register-file read data
ex_result  in  TAM  ALU output for the issuing instruction
mem_rdata  in  TAM  D-Data read data for the load in stage 0
stall_ext  in  1  freeze all stages
flush  in  1  kill the issuing instruction
opa, opb  out  TAM  forwarded operands
fwd_sel_a, fwd_sel_b  out  SEL_W  0 = register file, k = stage k-1
hazard_stall  out  1  load-use stall request to the decoder/PC
wb_write  out  1  register-file write enable
wb_rd  out  REG_AW  writeback address
wb_data  out  TAM  writeback data
retire_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Stage k fields: valid, write, load, rd, data. advance = !stall_ext.
- Issue: at a rising edge with advance, stage 0 <= {1, id_write, id_load, id_rd, ex_result} if id_valid & !hazard_stall & !flush; otherwise stage 0 <= bubble (valid = 0).
- Shift: at a rising edge with advance, stage k <= stage k-1 for k >= 1. On the 0->1 transfer, when stage 0 load = 1, data <= mem_rdata instead of the stored value.
- stall_ext = 1: every stage holds, including flush and issue. flush is sampled only on advancing edges.
- Match for stage k and operand x: valid & write & rd == id_rs_x.
- Forwarding is combinational. The lowest matching k wins (youngest first). Stage 0 is eligible only when load = 0. With no match, the operand comes from reg_a/reg_b and fwd_sel = 0.
- hazard_stall = id_valid & ((id_use_a & stage0 matches a & stage0.load) | same for b). This is combinational and independent of stall_ext. During a hazard the older stages still advance, so the stall lasts exactly 1 cycle unless stall_ext is asserted.
- Writeback: wb_write = last.valid & last.write & advance. wb_rd and wb_data reflect the last stage continuously.
- retire_cnt increments by 1 on each advancing edge where last.valid = 1. It wraps modulo 2^CNT_W.
- Reset, asynchronous, any time including mid-operation: all stage fields = 0 and retire_cnt = 0. Consequently wb_write = 0, hazard_stall = 0, fwd_sel = 0, opa/opb = reg_a/reg_b.
- Simultaneous flush and hazard: a bubble is issued and hazard_stall is still reported.

Decomposition:
- Package nrisc_pipe_pkg: stage record typedef (valid, write, load, rd, data); FWD_SEL_REGFILE = 0 constant; default widths.
- Sub-module nrisc_fwd_mux: per-operand priority compare plus mux, parametrised on FWD_DEPTH. Instantiated twice (a, b).

Test Plan:
1. Assert rst for 1 cycle while stages hold valid writes -> all stage valids 0, wb_write 0, retire_cnt 0, opa = reg_a immediately.
2. Issue R3 <= ex_result 0x0005, next cycle issue reading R3 (reg_a = 0x1111) -> opa = 0x0005, fwd_sel_a = 1; one cycle later opa = 0x0005, fwd_sel_a = 2; after that the register file is used, fwd_sel_a = 0.
3. Load R4, then an instruction using R4 as b -> hazard_stall = 1 for exactly 1 cycle and stage 0 becomes a bubble; mem_rdata = 0xBEEF is captured; next cycle opb = 0xBEEF, fwd_sel_b = 2, hazard_stall = 0.
4. Issue R2 <= 0x0001, then R2 <= 0x0002, then read R2 on both a and b -> opa = opb = 0x0002, fwd_sel = 1.
5. stall_ext = 1 for 3 cycles with a valid writeback in the last stage -> stages frozen, wb_write = 0 throughout, retire_cnt unchanged; after release it increments once.
6. flush = 1 with id_valid = 1 and id_rd = R5 -> no R5 entry enters stage 0; a later read of R5 gives fwd_sel = 0; with CNT_W = 4, 17 retirements -> retire_cnt = 1.

Source files
------------

// File: rtl/nrisc_pipe_pkg.sv
// Shared types and constants for the NRISC execute/writeback pipeline tracker.
// The width-independent control part of a stage record lives here; the top
// wraps it with the parametrised rd/data fields so every width stays tunable.
package nrisc_pipe_pkg;

   localparam int TAM_DEF       = 16;
   localparam int REG_AW_DEF    = 4;
   localparam int FWD_DEPTH_DEF = 2;
   localparam int CNT_W_DEF     = 16;

   // Forward-select value meaning "operand comes from the register file".
   localparam int FWD_SEL_REGFILE = 0;

   // Control flags carried by every in-flight stage.
   typedef struct packed {
      logic valid;
      logic write;
      logic load;
   } stage_ctrl_t;

   // A stage can supply a forwarded result when it holds a valid register
   // write. Stage 0 is excluded for loads: its D-Data value is not back yet.
   function automatic logic fwd_eligible(input stage_ctrl_t ctrl, input int stage_idx);
      return ctrl.valid & ctrl.write & ((stage_idx != 0) | ~ctrl.load);
   endfunction

endpackage

// File: rtl/nrisc_fwd_mux.sv
// Per-operand forwarding mux: picks the youngest eligible stage whose
// destination matches the source register, else the register-file value.
module nrisc_fwd_mux
   import nrisc_pipe_pkg::*;
#(
   parameter int TAM       = TAM_DEF,
   parameter int REG_AW    = REG_AW_DEF,
   parameter int FWD_DEPTH = FWD_DEPTH_DEF,
   parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
   input  stage_ctrl_t [FWD_DEPTH-1:0]             st_ctrl,
   input  logic        [FWD_DEPTH-1:0][REG_AW-1:0] st_rd,
   input  logic        [FWD_DEPTH-1:0][TAM-1:0]    st_data,
   input  logic        [REG_AW-1:0]                rs,
   input  logic        [TAM-1:0]                   reg_data,
   output logic        [TAM-1:0]                   op,
   output logic        [SEL_W-1:0]                 sel
);

   // Priority select: scan oldest to youngest so the youngest match is assigned last and wins.
   always_comb begin
      // NOTE: every output gets a default before any conditional assignment, so no latch is inferred.
      op  = reg_data;
      sel = SEL_W'(FWD_SEL_REGFILE);
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
         if (fwd_eligible(st_ctrl[k], k) && (st_rd[k] == rs)) begin
            op  = st_data[k];
            sel = SEL_W'(k + 1);
         end
      end
   end

endmodule

// File: rtl/nrisc_pipe_fwd.sv
// Execute/writeback pipeline tracker for the NRISC core. Tracks destination,
// control and result of every in-flight instruction, forwards the youngest
// matching result to both ALU operands, raises the load-use stall, drives the
// register-file writeback port and counts retired instructions.
module nrisc_pipe_fwd
   import nrisc_pipe_pkg::*;
#(
   parameter int TAM       = TAM_DEF,
   parameter int REG_AW    = REG_AW_DEF,
   parameter int FWD_DEPTH = FWD_DEPTH_DEF,   // legal range 2..4
   parameter int CNT_W     = CNT_W_DEF,
   parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic              id_write,
   input  logic              id_load,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [REG_AW-1:0] id_rs_a,
   input  logic [REG_AW-1:0] id_rs_b,
   input  logic              id_use_a,
   input  logic              id_use_b,
   input  logic [TAM-1:0]    reg_a,
   input  logic [TAM-1:0]    reg_b,
   input  logic [TAM-1:0]    ex_result,
   input  logic [TAM-1:0]    mem_rdata,
   input  logic              stall_ext,
   input  logic              flush,
   output logic [TAM-1:0]    opa,
   output logic [TAM-1:0]    opb,
   output logic [SEL_W-1:0]  fwd_sel_a,
   output logic [SEL_W-1:0]  fwd_sel_b,
   output logic              hazard_stall,
   output logic              wb_write,
   output logic [REG_AW-1:0] wb_rd,
   output logic [TAM-1:0]    wb_data,
   output logic [CNT_W-1:0]  retire_cnt
);

   localparam int LAST = FWD_DEPTH - 1;

   // Full stage record: shared control flags plus width-dependent payload.
   typedef struct packed {
      stage_ctrl_t       ctrl;
      logic [REG_AW-1:0] rd;
      logic [TAM-1:0]    data;
   } stage_t;

   stage_t [FWD_DEPTH-1:0] stage_q, stage_d;
   logic   [CNT_W-1:0]     retire_cnt_q, retire_cnt_d;

   logic advance;
   logic issue_ok;
   logic s0_load_wr;

   stage_ctrl_t [FWD_DEPTH-1:0]             st_ctrl;
   logic        [FWD_DEPTH-1:0][REG_AW-1:0] st_rd;
   logic        [FWD_DEPTH-1:0][TAM-1:0]    st_data;

   assign advance = ~stall_ext;

   // Load-use hazard: the instruction in stage 0 is a load writing a register the decoder reads now.
   always_comb begin
      s0_load_wr   = stage_q[0].ctrl.valid & stage_q[0].ctrl.write & stage_q[0].ctrl.load;
      hazard_stall = id_valid & s0_load_wr &
                     ((id_use_a & (stage_q[0].rd == id_rs_a)) |
                      (id_use_b & (stage_q[0].rd == id_rs_b)));
   end

   // Next pipeline state: issue or bubble into stage 0, shift older stages, count retirements.
   always_comb begin
      stage_d      = stage_q;
      retire_cnt_d = retire_cnt_q;
      issue_ok     = id_valid & ~hazard_stall & ~flush;

      if (advance) begin
         stage_d[0] = '0;
         if (issue_ok) begin
            stage_d[0].ctrl.valid = 1'b1;
            stage_d[0].ctrl.write = id_write;
            stage_d[0].ctrl.load  = id_load;
            stage_d[0].rd         = id_rd;
            stage_d[0].data       = ex_result;
         end

         for (int k = 1; k < FWD_DEPTH; k++) begin
            stage_d[k] = stage_q[k-1];
         end
         // A load's data arrives from D-Data while it sits in stage 0.
         if (stage_q[0].ctrl.load) begin
            stage_d[1].data = mem_rdata;
         end

         if (stage_q[LAST].ctrl.valid) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
         end
      end
   end

   // Pipeline and retire-counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_q      <= '0;
         retire_cnt_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all stages update from pre-edge values.
         stage_q      <= stage_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   // Split stage records into the flat views the forwarding muxes consume.
   always_comb begin
      for (int k = 0; k < FWD_DEPTH; k++) begin
         st_ctrl[k] = stage_q[k].ctrl;
         st_rd[k]   = stage_q[k].rd;
         st_data[k] = stage_q[k].data;
      end
   end

   nrisc_fwd_mux #(
      .TAM       (TAM),
      .REG_AW    (REG_AW),
      .FWD_DEPTH (FWD_DEPTH),
      .SEL_W     (SEL_W)
   ) u_fwd_a (
      .st_ctrl  (st_ctrl),
      .st_rd    (st_rd),
      .st_data  (st_data),
      .rs       (id_rs_a),
      .reg_data (reg_a),
      .op       (opa),
      .sel      (fwd_sel_a)
   );

   nrisc_fwd_mux #(
      .TAM       (TAM),
      .REG_AW    (REG_AW),
      .FWD_DEPTH (FWD_DEPTH),
      .SEL_W     (SEL_W)
   ) u_fwd_b (
      .st_ctrl  (st_ctrl),
      .st_rd    (st_rd),
      .st_data  (st_data),
      .rs       (id_rs_b),
      .reg_data (reg_b),
      .op       (opb),
      .sel      (fwd_sel_b)
   );

   // Writeback is only committed on an advancing edge; address and data track the last stage.
   assign wb_write   = stage_q[LAST].ctrl.valid & stage_q[LAST].ctrl.write & advance;
   assign wb_rd      = stage_q[LAST].rd;
   assign wb_data    = stage_q[LAST].data;
   assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_nrisc_pipe_fwd.sv
// Self-checking bench for nrisc_pipe_fwd: directed scenarios followed by a
// randomized run, all compared against an in-flight-instruction queue model.
module tb_nrisc_pipe_fwd;

   localparam int TAM    = 16;
   localparam int REG_AW = 4;
   localparam int D      = 2;
   localparam int CNT_W  = 4;
   localparam int SEL_W  = $clog2(D + 1);

   logic              clk = 1'b0;
   logic              rst;
   logic              id_valid, id_write, id_load;
   logic [REG_AW-1:0] id_rd, id_rs_a, id_rs_b;
   logic              id_use_a, id_use_b;
   logic [TAM-1:0]    reg_a, reg_b, ex_result, mem_rdata;
   logic              stall_ext, flush;
   logic [TAM-1:0]    opa, opb;
   logic [SEL_W-1:0]  fwd_sel_a, fwd_sel_b;
   logic              hazard_stall, wb_write;
   logic [REG_AW-1:0] wb_rd;
   logic [TAM-1:0]    wb_data;
   logic [CNT_W-1:0]  retire_cnt;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   nrisc_pipe_fwd #(
      .TAM       (TAM),
      .REG_AW    (REG_AW),
      .FWD_DEPTH (D),
      .CNT_W     (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_write     (id_write),
      .id_load      (id_load),
      .id_rd        (id_rd),
      .id_rs_a      (id_rs_a),
      .id_rs_b      (id_rs_b),
      .id_use_a     (id_use_a),
      .id_use_b     (id_use_b),
      .reg_a        (reg_a),
      .reg_b        (reg_b),
      .ex_result    (ex_result),
      .mem_rdata    (mem_rdata),
      .stall_ext    (stall_ext),
      .flush        (flush),
      .opa          (opa),
      .opb          (opb),
      .fwd_sel_a    (fwd_sel_a),
      .fwd_sel_b    (fwd_sel_b),
      .hazard_stall (hazard_stall),
      .wb_write     (wb_write),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .retire_cnt   (retire_cnt)
   );

   // ---------------- reference model: queue of in-flight instructions, youngest at index 0
   typedef struct {
      bit              valid;
      bit              write;
      bit              load;
      bit [REG_AW-1:0] rd;
      bit [TAM-1:0]    data;
   } ent_t;

   ent_t        m_pipe[$];
   int unsigned m_cnt;

   function automatic ent_t bubble();
      ent_t e;
      e.valid = 0; e.write = 0; e.load = 0; e.rd = '0; e.data = '0;
      return e;
   endfunction

   task automatic model_reset();
      m_pipe.delete();
      for (int i = 0; i < D; i++) m_pipe.push_back(bubble());
      m_cnt = 0;
   endtask

   // Youngest in-flight writer of rs supplies the operand; a load still in stage 0 cannot.
   function automatic void model_fwd(input bit [REG_AW-1:0] rs, input bit [TAM-1:0] rf,
                                     output bit [TAM-1:0] d, output int sel);
      d   = rf;
      sel = 0;
      for (int k = 0; k < D; k++) begin
         if (sel == 0 && m_pipe[k].valid && m_pipe[k].write && m_pipe[k].rd == rs &&
             !(k == 0 && m_pipe[k].load))
         begin
            d   = m_pipe[k].data;
            sel = k + 1;
         end
      end
   endfunction

   function automatic bit model_hazard();
      ent_t y;
      y = m_pipe[0];
      if (!id_valid || !y.valid || !y.write || !y.load) return 0;
      return (id_use_a && y.rd == id_rs_a) || (id_use_b && y.rd == id_rs_b);
   endfunction

   task automatic model_step();
      bit   haz;
      ent_t n;
      ent_t t;
      haz = model_hazard();
      if (!stall_ext) begin
         if (m_pipe[D-1].valid) m_cnt = (m_cnt + 1) % (1 << CNT_W);
         void'(m_pipe.pop_back());
         if (m_pipe[0].load) begin
            t = m_pipe[0];
            t.data = mem_rdata;
            m_pipe[0] = t;
         end
         n = bubble();
         if (id_valid && !haz && !flush) begin
            n.valid = 1; n.write = id_write; n.load = id_load; n.rd = id_rd; n.data = ex_result;
         end
         m_pipe.push_front(n);
      end
   endtask

   // ---------------- checking
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      bit [TAM-1:0] ea, eb;
      int           sa, sb;
      ent_t         last;
      model_fwd(id_rs_a, reg_a, ea, sa);
      model_fwd(id_rs_b, reg_b, eb, sb);
      last = m_pipe[D-1];
      check("opa", opa, ea);
      check("fwd_sel_a", fwd_sel_a, sa);
      check("opb", opb, eb);
      check("fwd_sel_b", fwd_sel_b, sb);
      check("hazard_stall", hazard_stall, model_hazard());
      check("wb_write", wb_write, last.valid && last.write && !stall_ext);
      if (last.valid) begin
         check("wb_rd", wb_rd, last.rd);
         check("wb_data", wb_data, last.data);
      end
      check("retire_cnt", retire_cnt, m_cnt);
   endtask

   // Inputs are driven just after a rising edge; tick checks, updates the model, then clocks.
   task automatic tick();
      #2;
      check_model();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      id_valid = 0; id_write = 0; id_load = 0; id_rd = '0;
      id_rs_a = '0; id_rs_b = '0; id_use_a = 0; id_use_b = 0;
      stall_ext = 0; flush = 0;
   endtask

   task automatic issue(input bit wr, input bit ld, input logic [REG_AW-1:0] rd,
                        input logic [REG_AW-1:0] rsa, input logic [REG_AW-1:0] rsb,
                        input bit ua, input bit ub, input logic [TAM-1:0] res);
      id_valid = 1; id_write = wr; id_load = ld; id_rd = rd;
      id_rs_a = rsa; id_rs_b = rsb; id_use_a = ua; id_use_b = ub;
      ex_result = res; stall_ext = 0; flush = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      model_reset();
      @(posedge clk);
      #1;
      rst = 0;
   endtask

   int unsigned saved_cnt;

   initial begin
      rst = 1;
      idle();
      reg_a = 16'h1111; reg_b = 16'h2222; ex_result = '0; mem_rdata = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 0;

      // --- 1: asynchronous reset mid-operation
      issue(1, 0, 4'd8,  0, 0, 0, 0, 16'h0808); tick();
      issue(1, 0, 4'd9,  0, 0, 0, 0, 16'h0909); tick();
      issue(1, 0, 4'd10, 0, 0, 0, 0, 16'h0A0A); tick();
      idle(); id_rs_a = 4'd9; id_rs_b = 4'd10;
      settle();
      check("pre_rst_opa", opa, 16'h0909);
      check("pre_rst_cnt", retire_cnt, 1);
      rst = 1;
      model_reset();
      #1;
      check("rst_opa", opa, 16'h1111);
      check("rst_opb", opb, 16'h2222);
      check("rst_sel_a", fwd_sel_a, 0);
      check("rst_wb_write", wb_write, 0);
      check("rst_cnt", retire_cnt, 0);
      check("rst_hazard", hazard_stall, 0);
      @(posedge clk);
      #1;
      rst = 0;
      tick();

      // --- 2: forward from stage 0, then stage 1, then register file
      issue(1, 0, 4'd3, 0, 0, 0, 0, 16'h0005); tick();
      issue(0, 0, 4'd0, 4'd3, 0, 1, 0, 16'h0000);
      settle();
      check("t2_opa_s0", opa, 16'h0005);
      check("t2_sel_s0", fwd_sel_a, 1);
      tick();
      settle();
      check("t2_opa_s1", opa, 16'h0005);
      check("t2_sel_s1", fwd_sel_a, 2);
      tick();
      settle();
      check("t2_opa_rf", opa, 16'h1111);
      check("t2_sel_rf", fwd_sel_a, 0);
      tick();
      idle(); tick();

      // --- 3: load-use hazard, mem_rdata capture
      issue(1, 1, 4'd4, 0, 0, 0, 0, 16'hDEAD); tick();
      issue(1, 0, 4'd11, 0, 4'd4, 0, 1, 16'h0011);
      mem_rdata = 16'hBEEF;
      settle();
      check("t3_hazard", hazard_stall, 1);
      check("t3_sel_b_ld", fwd_sel_b, 0);
      tick();
      mem_rdata = 16'h0000;
      settle();
      check("t3_hazard_clr", hazard_stall, 0);
      check("t3_opb", opb, 16'hBEEF);
      check("t3_sel_b", fwd_sel_b, 2);
      tick();
      idle(); tick();

      // --- 4: youngest of two writers wins on both operands
      issue(1, 0, 4'd2, 0, 0, 0, 0, 16'h0001); tick();
      issue(1, 0, 4'd2, 0, 0, 0, 0, 16'h0002); tick();
      issue(0, 0, 4'd0, 4'd2, 4'd2, 1, 1, 16'h0000);
      settle();
      check("t4_opa", opa, 16'h0002);
      check("t4_opb", opb, 16'h0002);
      check("t4_sel_a", fwd_sel_a, 1);
      check("t4_sel_b", fwd_sel_b, 1);
      tick();
      idle(); tick();

      // --- 5: external stall freezes writeback and the counter
      issue(1, 0, 4'd6, 0, 0, 0, 0, 16'h0066); tick();
      idle(); tick();
      saved_cnt = m_cnt;
      for (int i = 0; i < 3; i++) begin
         issue(1, 0, 4'd7, 0, 0, 0, 0, 16'h0077);
         stall_ext = 1;
         settle();
         check("t5_wb_write", wb_write, 0);
         check("t5_wb_rd", wb_rd, 6);
         check("t5_cnt", retire_cnt, saved_cnt);
         tick();
      end
      idle();
      settle();
      check("t5_wb_release", wb_write, 1);
      tick();
      settle();
      check("t5_cnt_inc", retire_cnt, (saved_cnt + 1) % 16);
      tick();

      // --- simultaneous flush and hazard
      issue(1, 1, 4'd7, 0, 0, 0, 0, 16'h0000); tick();
      issue(1, 0, 4'd12, 4'd7, 0, 1, 0, 16'h0C0C);
      flush = 1;
      settle();
      check("fh_hazard", hazard_stall, 1);
      tick();
      idle(); id_rs_a = 4'd12;
      settle();
      check("fh_sel_a", fwd_sel_a, 0);
      tick();

      // --- 6a: flushed instruction never enters the pipe
      issue(1, 0, 4'd5, 0, 0, 0, 0, 16'h0055);
      flush = 1;
      tick();
      idle(); id_rs_a = 4'd5;
      settle();
      check("t6_sel_s0", fwd_sel_a, 0);
      tick();
      settle();
      check("t6_sel_s1", fwd_sel_a, 0);
      tick();

      // --- randomized run
      for (int c = 0; c < 400; c++) begin
         reg_a     = TAM'($urandom);
         reg_b     = TAM'($urandom);
         ex_result = TAM'($urandom);
         mem_rdata = TAM'($urandom);
         id_valid  = ($urandom_range(0, 9) < 8);
         id_write  = ($urandom_range(0, 9) < 7);
         id_load   = ($urandom_range(0, 9) < 3);
         id_rd     = REG_AW'($urandom_range(0, 3));
         id_rs_a   = REG_AW'($urandom_range(0, 3));
         id_rs_b   = REG_AW'($urandom_range(0, 3));
         id_use_a  = $urandom_range(0, 1);
         id_use_b  = $urandom_range(0, 1);
         stall_ext = ($urandom_range(0, 9) < 2);
         flush     = ($urandom_range(0, 9) < 1);
         tick();
      end

      // --- 6b: 17 retirements wrap a 4-bit counter to 1
      idle();
      do_reset();
      for (int i = 0; i < 17; i++) begin
         issue(1, 0, REG_AW'(i), 0, 0, 0, 0, TAM'(i));
         tick();
      end
      idle(); tick(); tick();
      settle();
      check("t6_cnt_wrap", retire_cnt, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
